// File: rtl/s510_timing_pkg.sv
// Shared timing constants for the s510 pixel/line counter generator.
// Decode tables are packed with entry 0 in the least-significant slot.
package s510_timing_pkg;

    localparam int PCNT_W    = 8;
    localparam int CNT_W     = 10;
    localparam int PCNT_NDEC = 5;
    localparam int CNT_NDEC  = 13;

    // pixel decodes, index 0..4: 6, 12, 17, 27, 241
    localparam logic [PCNT_NDEC-1:0][PCNT_W-1:0] PCNT_DEC = {
        8'd241, 8'd27, 8'd17, 8'd12, 8'd6
    };

    // line decodes, index 0..12: 10, 13, 21, 44, 45, 261, 272, 283, 284, 509, 511, 567, 591
    localparam logic [CNT_NDEC-1:0][CNT_W-1:0] CNT_DEC = {
        10'd591, 10'd567, 10'd511, 10'd509, 10'd284, 10'd283, 10'd272,
        10'd261, 10'd45,  10'd44,  10'd21,  10'd13,  10'd10
    };

endpackage

// File: rtl/s510_cnt_dec.sv
// One counter with clear > advance > hold priority, a wrap pulse and
// registered equality decodes taken from the next-state value.
module s510_cnt_dec #(
    parameter int                          WIDTH    = 8,
    parameter int                          NDEC     = 1,
    parameter logic [NDEC-1:0][WIDTH-1:0]  DEC_VALS = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic [NDEC-1:0]  dec_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [NDEC-1:0]  dec_q, dec_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (adv_i) begin
            cnt_d  = cnt_q + WIDTH'(1);
            wrap_d = &cnt_q;
        end
    end

    // decoding the next value makes each strobe line up with its count
    always_comb begin
        dec_d = '0;
        for (int i = 0; i < NDEC; i++) begin
            dec_d[i] = (cnt_d == DEC_VALS[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            dec_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dec_q  <= dec_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign dec_o  = dec_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/s510_cnt_gen.sv
// Pixel (8-bit) and line (10-bit) counters with registered decode strobes
// for the sync controller; the two counters run independently.
module s510_cnt_gen
    import s510_timing_pkg::*;
(
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              pc,
    input  logic              pclr,
    input  logic              csm,
    input  logic              cclr,
    output logic              pcnt6,
    output logic              pcnt12,
    output logic              pcnt17,
    output logic              pcnt27,
    output logic              pcnt241,
    output logic              cnt10,
    output logic              cnt13,
    output logic              cnt21,
    output logic              cnt44,
    output logic              cnt45,
    output logic              cnt261,
    output logic              cnt272,
    output logic              cnt283,
    output logic              cnt284,
    output logic              cnt509,
    output logic              cnt511,
    output logic              cnt567,
    output logic              cnt591,
    output logic [PCNT_W-1:0] pcnt_q,
    output logic [CNT_W-1:0]  cnt_q,
    output logic              cnt_wrap
);

    logic [PCNT_NDEC-1:0] pdec;
    logic [CNT_NDEC-1:0]  ldec;
    logic                 pix_wrap_unused;

    s510_cnt_dec #(
        .WIDTH    (PCNT_W),
        .NDEC     (PCNT_NDEC),
        .DEC_VALS (PCNT_DEC)
    ) u_pix (
        .clk_i  (blif_clk_net),
        .rst_i  (blif_reset_net),
        .clr_i  (pclr),
        .adv_i  (pc),
        .cnt_o  (pcnt_q),
        .dec_o  (pdec),
        .wrap_o (pix_wrap_unused)
    );

    s510_cnt_dec #(
        .WIDTH    (CNT_W),
        .NDEC     (CNT_NDEC),
        .DEC_VALS (CNT_DEC)
    ) u_line (
        .clk_i  (blif_clk_net),
        .rst_i  (blif_reset_net),
        .clr_i  (cclr),
        .adv_i  (csm),
        .cnt_o  (cnt_q),
        .dec_o  (ldec),
        .wrap_o (cnt_wrap)
    );

    assign pcnt6   = pdec[0];
    assign pcnt12  = pdec[1];
    assign pcnt17  = pdec[2];
    assign pcnt27  = pdec[3];
    assign pcnt241 = pdec[4];

    assign cnt10   = ldec[0];
    assign cnt13   = ldec[1];
    assign cnt21   = ldec[2];
    assign cnt44   = ldec[3];
    assign cnt45   = ldec[4];
    assign cnt261  = ldec[5];
    assign cnt272  = ldec[6];
    assign cnt283  = ldec[7];
    assign cnt284  = ldec[8];
    assign cnt509  = ldec[9];
    assign cnt511  = ldec[10];
    assign cnt567  = ldec[11];
    assign cnt591  = ldec[12];

endmodule

// File: tb/tb_s510_cnt_gen.sv
// Directed bench for s510_cnt_gen: a vector table plus hand-written
// sequences for sweeps, wraps, clears and mid-count reset.
module tb_s510_cnt_gen;

    logic       clk = 1'b0;
    logic       rst, pc, pclr, csm, cclr;
    logic       pcnt6, pcnt12, pcnt17, pcnt27, pcnt241;
    logic       cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272, cnt283;
    logic       cnt284, cnt509, cnt511, cnt567, cnt591;
    logic [7:0] pcnt_q;
    logic [9:0] cnt_q;
    logic       cnt_wrap;

    int n_cmp = 0;
    int n_err = 0;

    localparam int LVALS [13] = '{10, 13, 21, 44, 45, 261, 272, 283, 284, 509, 511, 567, 591};

    s510_cnt_gen dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .pc       (pc),
        .pclr     (pclr),
        .csm      (csm),
        .cclr     (cclr),
        .pcnt6    (pcnt6),
        .pcnt12   (pcnt12),
        .pcnt17   (pcnt17),
        .pcnt27   (pcnt27),
        .pcnt241  (pcnt241),
        .cnt10    (cnt10),
        .cnt13    (cnt13),
        .cnt21    (cnt21),
        .cnt44    (cnt44),
        .cnt45    (cnt45),
        .cnt261   (cnt261),
        .cnt272   (cnt272),
        .cnt283   (cnt283),
        .cnt284   (cnt284),
        .cnt509   (cnt509),
        .cnt511   (cnt511),
        .cnt567   (cnt567),
        .cnt591   (cnt591),
        .pcnt_q   (pcnt_q),
        .cnt_q    (cnt_q),
        .cnt_wrap (cnt_wrap)
    );

    always #5 clk = ~clk;

    wire [4:0]  pstr = {pcnt241, pcnt27, pcnt17, pcnt12, pcnt6};
    wire [12:0] lstr = {cnt591, cnt567, cnt511, cnt509, cnt284, cnt283, cnt272,
                        cnt261, cnt45, cnt44, cnt21, cnt13, cnt10};

    typedef struct {
        logic       rst, pc, pclr, csm, cclr;
        logic [7:0] e_p;
        logic [9:0] e_c;
        logic [4:0] e_ps;
        logic [12:0] e_ls;
        logic       e_w;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic p, input logic pcl, input logic c, input logic ccl);
        rst = r; pc = p; pclr = pcl; csm = c; cclr = ccl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] lexp(input int c);
        logic [12:0] r = '0;
        for (int k = 0; k < 13; k++) if (c == LVALS[k]) r[k] = 1'b1;
        return r;
    endfunction

    int pulses [13];
    int wraps;
    int ecnt;
    bit saw591;

    initial begin
        rst = 1'b1; pc = 1'b0; pclr = 1'b0; csm = 1'b0; cclr = 1'b0;

        //            rst   pc    pclr  csm   cclr  pcnt   cnt     pstr      lstr    wrap
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 10'd0, 5'b00000, 13'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 10'd1, 5'b00000, 13'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 10'd2, 5'b00000, 13'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 10'd3, 5'b00000, 13'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 10'd4, 5'b00000, 13'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 10'd5, 5'b00000, 13'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd6, 10'd6, 5'b00001, 13'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7, 10'd6, 5'b00000, 13'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd7, 10'd7, 5'b00000, 13'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 10'd7, 5'b00000, 13'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 10'd0, 5'b00000, 13'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 10'd0, 5'b00000, 13'd0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            tick(vecs[i].rst, vecs[i].pc, vecs[i].pclr, vecs[i].csm, vecs[i].cclr);
            check($sformatf("vec%0d_pcnt", i), 32'(pcnt_q), 32'(vecs[i].e_p));
            check($sformatf("vec%0d_cnt", i), 32'(cnt_q), 32'(vecs[i].e_c));
            check($sformatf("vec%0d_pstr", i), 32'(pstr), 32'(vecs[i].e_ps));
            check($sformatf("vec%0d_lstr", i), 32'(lstr), 32'(vecs[i].e_ls));
            check($sformatf("vec%0d_wrap", i), 32'(cnt_wrap), 32'(vecs[i].e_w));
        end

        // full line sweep 0 -> 1023 -> 0
        tick(1, 0, 0, 0, 0);
        for (int k = 0; k < 13; k++) pulses[k] = 0;
        wraps = 0;
        for (int i = 0; i < 1024; i++) begin
            tick(0, 0, 0, 1, 0);
            ecnt = (i + 1) % 1024;
            for (int k = 0; k < 13; k++) if (lstr[k]) pulses[k]++;
            if (cnt_wrap) wraps++;
            check($sformatf("sweep%0d", i), {7'd0, cnt_wrap, lstr, cnt_q},
                  {7'd0, (i == 1023), lexp(ecnt), 10'(ecnt)});
        end
        for (int k = 0; k < 13; k++)
            check($sformatf("sweep_pulses_cnt%0d", LVALS[k]), 32'(pulses[k]), 32'd1);
        check("sweep_wrap_pulses", 32'(wraps), 32'd1);
        tick(0, 0, 0, 0, 0);
        check("wrap_drop", {cnt_wrap, cnt_q}, {1'b0, 10'd0});

        // clear from 1023 must not pulse wrap
        repeat (1023) tick(0, 0, 0, 1, 0);
        check("at1023", 32'(cnt_q), 32'd1023);
        tick(0, 0, 0, 1, 1);
        check("clr1023", {cnt_wrap, cnt_q}, {1'b0, 10'd0});

        // clear beats advance at 283
        tick(1, 0, 0, 0, 0);
        repeat (283) tick(0, 0, 0, 1, 0);
        check("at283", {cnt_q, lstr}, {10'd283, lexp(283)});
        tick(0, 0, 0, 1, 1);
        check("clr283", {cnt_wrap, lstr, cnt_q}, {1'b0, 13'd0, 10'd0});

        // pc every other cycle up to 241, then on to the 255 -> 0 wrap
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 241; i++) begin
            tick(0, 1, 0, 0, 0);
            if (i < 240) tick(0, 0, 0, 0, 0);
        end
        check("p241_a", {pcnt_q, pstr}, {8'd241, 5'b10000});
        tick(0, 0, 0, 0, 0);
        check("p241_b", {pcnt_q, pstr}, {8'd241, 5'b10000});
        tick(0, 1, 0, 0, 0);
        check("p242", {pcnt_q, pstr}, {8'd242, 5'b00000});
        repeat (13) tick(0, 1, 0, 0, 0);
        check("p255", 32'(pcnt_q), 32'd255);
        tick(0, 1, 0, 0, 0);
        check("p_wrap", {pcnt_q, pstr, cnt_wrap}, {8'd0, 5'b00000, 1'b0});

        // reset at 590 with csm high
        tick(1, 0, 0, 0, 0);
        repeat (590) tick(0, 0, 0, 1, 0);
        check("at590", 32'(cnt_q), 32'd590);
        tick(1, 0, 0, 1, 0);
        check("rst590", {lstr, cnt_q}, {13'd0, 10'd0});
        saw591 = cnt591;
        repeat (4) begin
            tick(0, 0, 0, 0, 0);
            saw591 = saw591 | cnt591;
        end
        check("no591", 32'(saw591), 32'd0);
        check("hold_after_rst", 32'(cnt_q), 32'd0);
        tick(0, 0, 0, 1, 0);
        check("resume", 32'(cnt_q), 32'd1);

        // pclr with csm at pcnt 17 / cnt 20
        tick(1, 0, 0, 0, 0);
        repeat (17) tick(0, 1, 0, 1, 0);
        repeat (3) tick(0, 0, 0, 1, 0);
        check("pre_p17", {pcnt_q, pstr, cnt_q}, {8'd17, 5'b00100, 10'd20});
        repeat (5) tick(0, 0, 0, 0, 0);
        check("freeze", {pcnt_q, pstr, cnt_q}, {8'd17, 5'b00100, 10'd20});
        tick(0, 0, 1, 1, 0);
        check("pclr_pcnt", {pcnt_q, pstr}, {8'd0, 5'b00000});
        check("csm_cnt21", {cnt_q, lstr}, {10'd21, lexp(21)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/s510_cnt_gen.md
S510_CNT_GEN -- requirements
Module: s510_cnt_gen

Interface
REQ-001 SHALL have port blif_clk_net, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port blif_reset_net, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port pc, input, 1 bit: pixel-counter advance request from the sync controller.
REQ-004 SHALL have port pclr, input, 1 bit: pixel-counter clear request.
REQ-005 SHALL have port csm, input, 1 bit: line-counter advance request.
REQ-006 SHALL have port cclr, input, 1 bit: line-counter clear request.
REQ-007 SHALL have outputs pcnt6, pcnt12, pcnt17, pcnt27, pcnt241, each 1 bit: the pixel-count decode strobes.
REQ-008 SHALL have outputs cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272, cnt283, cnt284, cnt509, cnt511, cnt567, cnt591, each 1 bit: the line-count decode strobes.
REQ-009 SHALL have output pcnt_q, 8 bits: current pixel count.
REQ-010 SHALL have output cnt_q, 10 bits: current line count.
REQ-011 SHALL have output cnt_wrap, 1 bit: one-cycle pulse when the line counter wraps from 1023 to 0.

Function
REQ-012 Pixel counter SHALL update each edge with priority pclr > pc > hold: pclr loads 0; pc alone loads pcnt_q+1 modulo 256.
REQ-013 Line counter SHALL update each edge with priority cclr > csm > hold: cclr loads 0; csm alone loads cnt_q+1 modulo 1024.
REQ-014 The two counters SHALL be independent; simultaneous requests on both counters SHALL each take effect in the same cycle.
REQ-015 Each strobe pcntN / cntN SHALL be a register loaded from (next counter value == N), so it is high exactly in the cycles where the matching count register equals N, with no combinational path from inputs to outputs.
REQ-016 All outputs SHALL be registered.
REQ-017 pcnt_q SHALL wrap 255 -> 0 on pc without clear, with no flag.
REQ-018 cnt_wrap SHALL be high for exactly the one cycle after an edge where cnt_q went 1023 -> 0 by csm; a clear from 1023 SHALL NOT assert it.
REQ-019 A clear asserted together with an advance SHALL win, and the strobes SHALL reflect count 0 on the following cycle.
REQ-020 Holding pc or csm low SHALL freeze the corresponding count and strobe values indefinitely.

Reset
REQ-021 With blif_reset_net high at a rising edge, pcnt_q and cnt_q SHALL be 0, and all strobes and cnt_wrap SHALL be 0.
REQ-022 Reset SHALL override pc, pclr, csm and cclr in the same cycle, including reset asserted mid-count.
REQ-023 Counting SHALL resume from 0 on the first edge after reset deasserts.

Structure
REQ-024 Counter widths (8 and 10) and all decode constants (6, 12, 17, 27, 241; 10, 13, 21, 44, 45, 261, 272, 283, 284, 509, 511, 567, 591) SHALL live in a shared package, s510_timing_pkg.
REQ-025 A parameterised sub-module, s510_cnt_dec, SHALL implement one counter (width parameter, clear/advance priority, wrap pulse) plus its registered equality decodes.
REQ-026 It SHALL be instantiated once for the pixel counter (8 bits, 5 decodes) and once for the line counter (10 bits, 13 decodes).

Verification
REQ-027 Reset, then pc high for 6 cycles -> pcnt_q = 6 and pcnt6 = 1 on the 6th cycle after reset release, and pcnt6 = 0 one cycle later if pc stays high.
REQ-028 Line counter at 283 with csm and cclr both high -> cnt_q = 0, cnt283 = 0, cnt284 = 0 next cycle, and no cnt_wrap.
REQ-029 csm held for 1024 cycles from 0 -> each of the 13 cnt strobes pulses exactly once at its value, and cnt_wrap pulses once at the 1023 -> 0 step.
REQ-030 pc toggled every other cycle up to 241 -> pcnt241 stays high for the 2 cycles the count holds at 241.
REQ-031 Reset asserted with cnt_q = 590 and csm high -> next cycle cnt_q = 0 and cnt591 never asserts.
REQ-032 pclr and csm asserted together with pcnt_q = 17 and cnt_q = 20 -> next cycle pcnt_q = 0, pcnt17 = 0, cnt_q = 21, cnt21 = 1.
